// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven owner of operand registers A/B wrapped around an external combinational ALU.
// Build option: define ALU_FLAGS_EN to generate registered {C,N,Z} flags; otherwise res_flags is tied to 3'b000.
module alu_sequencer #(
  parameter int         WIDTH   = 8,
  parameter logic [2:0] IDLE_OP = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_flags,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [1:0] {K_NOP, K_LOAD_A, K_LOAD_B, K_ALU} kind_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [2:0]       op_q, op_d;
  logic             dst_q, dst_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [2:0]       alu_s_q, alu_s_d;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    op_d       = op_q;
    dst_d      = dst_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (kind_t'(cmd_kind))
            K_LOAD_A: a_d = cmd_imm;
            K_LOAD_B: b_d = cmd_imm;
            K_ALU: begin
              op_d    = cmd_op;
              dst_d   = cmd_dst;
              state_d = S_EXEC;
            end
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        res_data_d = alu_out;
        if (dst_q) b_d = alu_out;
        else       a_d = alu_out;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs and the ALU opcode are decoded from the next state so they come straight off flops.
    cmd_ready_d = (state_d == S_IDLE);
    res_valid_d = (state_d == S_RESP);
    alu_s_d     = (state_d == S_EXEC) ? op_d : IDLE_OP;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and clears every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      op_q        <= IDLE_OP;
      dst_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      alu_s_q     <= IDLE_OP;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      alu_s_q     <= alu_s_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       carry;

  always_comb begin
    // A+B overflows exactly when A exceeds the one's complement of B.
    case (op_q)
      OP_ADD:  carry = (a_q > ~b_q);
      OP_SUB:  carry = (a_q < b_q);
      OP_SHL:  carry = a_q[WIDTH-1];
      OP_SHR:  carry = a_q[0];
      default: carry = 1'b0;
    endcase
    flags_d = flags_q;
    if (state_q == S_EXEC) flags_d = {carry, alu_out[WIDTH-1], (alu_out == '0)};
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign res_flags = flags_q;
`else
  assign res_flags = 3'b000;
`endif

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign alu_s     = alu_s_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_data  = res_data_q;
  assign reg_a     = a_q;
  assign reg_b     = b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: an 8-bit ALU model closes the datapath loop, expectations are hand-computed.
// Flag expectations follow the ALU_FLAGS_EN build option.
module tb_alu_sequencer;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [2:0] cmd_op;
  logic       cmd_dst;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_s;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_flags;
  logic [7:0] reg_a, reg_b;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.WIDTH(8), .IDLE_OP(3'b000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .reg_a(reg_a), .reg_b(reg_b)
  );

  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    case (alu_s)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b101:  alu_out = ~alu_a;
      3'b110:  alu_out = alu_a << 1;
      default: alu_out = alu_a >> 1;
    endcase
  end

  function automatic logic [2:0] fl(input logic [2:0] f);
    return FLAGS_ON ? f : 3'b000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] kind, input logic [7:0] imm);
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_imm   = imm;
    step();
    cmd_valid = 1'b0;
  endtask

  // Issues one ALU command with res_ready high and checks EXEC, RESP and the return to IDLE.
  task automatic run_alu(input string name, input logic [2:0] op, input logic dst,
                         input logic [7:0] exp_data, input logic [2:0] exp_flags,
                         input logic [7:0] exp_a, input logic [7:0] exp_b);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_before: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_kind = 2'b11; cmd_op = op; cmd_dst = dst; res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, res_valid, alu_s} !== {1'b0, 1'b0, op}) begin
      errors++; $display("FAIL %s_exec: got rdy/vld/s %b%b/%b want 00/%b", name, cmd_ready, res_valid, alu_s, op);
    end
    step();
    checks++;
    if ({cmd_ready, res_valid, alu_s} !== 5'b01000) begin
      errors++; $display("FAIL %s_resp: got rdy/vld/s %b%b/%b want 01/000", name, cmd_ready, res_valid, alu_s);
    end
    checks++;
    if (res_data !== exp_data) begin
      errors++; $display("FAIL %s_data: got %h want %h", name, res_data, exp_data);
    end
    checks++;
    if (res_flags !== fl(exp_flags)) begin
      errors++; $display("FAIL %s_flags: got %b want %b", name, res_flags, fl(exp_flags));
    end
    checks++;
    if ({reg_a, reg_b} !== {exp_a, exp_b}) begin
      errors++; $display("FAIL %s_regs: got %h/%h want %h/%h", name, reg_a, reg_b, exp_a, exp_b);
    end
    step();
    res_ready = 1'b0;
    checks++;
    if ({cmd_ready, res_valid} !== 2'b10) begin
      errors++; $display("FAIL %s_idle: got rdy/vld %b%b want 10", name, cmd_ready, res_valid);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if ({cmd_ready, res_valid, alu_s} !== 5'b10000) begin
      errors++; $display("FAIL %s_ctrl: got rdy/vld/s %b%b/%b want 10/000", name, cmd_ready, res_valid, alu_s);
    end
    checks++;
    if ({reg_a, reg_b, res_data, res_flags} !== 27'd0) begin
      errors++; $display("FAIL %s_data: got a=%h b=%h d=%h f=%b want all zero", name, reg_a, reg_b, res_data, res_flags);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_load_add();
    load(2'b01, 8'h05);
    checks++;
    if ({cmd_ready, reg_a} !== {1'b1, 8'h05}) begin
      errors++; $display("FAIL load_a: got rdy=%b a=%h want 1/05", cmd_ready, reg_a);
    end
    load(2'b10, 8'h03);
    checks++;
    if ({reg_a, reg_b} !== 16'h0503) begin
      errors++; $display("FAIL load_b: got %h/%h want 05/03", reg_a, reg_b);
    end
    run_alu("add", 3'b000, 1'b0, 8'h08, 3'b000, 8'h08, 8'h03);
  endtask

  task automatic test_nop();
    cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_op = 3'b000; cmd_imm = 8'hAA;
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, res_valid, alu_s, reg_a, reg_b} !== {1'b1, 1'b0, 3'b000, 8'h08, 8'h03}) begin
      errors++; $display("FAIL nop: got rdy/vld/s %b%b/%b a=%h b=%h want 10/000 08 03", cmd_ready, res_valid, alu_s, reg_a, reg_b);
    end
  endtask

  task automatic test_arith();
    load(2'b01, 8'hF0); load(2'b10, 8'h20);
    run_alu("add_carry", 3'b000, 1'b0, 8'h10, 3'b100, 8'h10, 8'h20);
    load(2'b01, 8'h03); load(2'b10, 8'h03);
    run_alu("sub_zero", 3'b001, 1'b1, 8'h00, 3'b001, 8'h03, 8'h00);
  endtask

  task automatic test_unary();
    load(2'b01, 8'h81);
    run_alu("shl", 3'b110, 1'b1, 8'h02, 3'b100, 8'h81, 8'h02);
    run_alu("shr", 3'b111, 1'b1, 8'h40, 3'b100, 8'h81, 8'h40);
    load(2'b01, 8'h0F);
    run_alu("not", 3'b101, 1'b1, 8'hF0, 3'b010, 8'h0F, 8'hF0);
  endtask

  // Each result feeds the next command through A or B.
  task automatic test_logic_chain();
    load(2'b01, 8'h0C); load(2'b10, 8'h0A);
    run_alu("and", 3'b010, 1'b1, 8'h08, 3'b000, 8'h0C, 8'h08);
    run_alu("or",  3'b011, 1'b0, 8'h0C, 3'b000, 8'h0C, 8'h08);
    run_alu("xor", 3'b100, 1'b0, 8'h04, 3'b000, 8'h04, 8'h08);
    run_alu("sub_borrow", 3'b001, 1'b0, 8'hFC, 3'b110, 8'hFC, 8'h08);
  endtask

  task automatic test_backpressure();
    load(2'b01, 8'h01); load(2'b10, 8'h02);
    cmd_valid = 1'b1; cmd_kind = 2'b11; cmd_op = 3'b000; cmd_dst = 1'b0; res_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    cmd_kind = 2'b01; cmd_imm = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i % 2 == 0);
      step();
      checks++;
      if ({cmd_ready, res_valid, alu_s, res_data, reg_a} !== {1'b0, 1'b1, 3'b000, 8'h03, 8'h03}) begin
        errors++; $display("FAIL stall_%0d: got rdy/vld/s %b%b/%b d=%h a=%h want 01/000 03 03", i, cmd_ready, res_valid, alu_s, res_data, reg_a);
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if ({cmd_ready, res_valid, reg_a} !== {1'b1, 1'b0, 8'h03}) begin
      errors++; $display("FAIL stall_release: got rdy/vld %b%b a=%h want 10 03", cmd_ready, res_valid, reg_a);
    end
  endtask

  task automatic test_reset_mid_op();
    load(2'b01, 8'h11); load(2'b10, 8'h22);
    cmd_valid = 1'b1; cmd_kind = 2'b11; cmd_op = 3'b000; cmd_dst = 1'b0;
    step();
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_exec");

    load(2'b01, 8'h11); load(2'b10, 8'h22);
    cmd_valid = 1'b1; cmd_kind = 2'b11; cmd_op = 3'b000; cmd_dst = 1'b1; res_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if ({res_valid, res_data, reg_b} !== {1'b1, 8'h33, 8'h33}) begin
      errors++; $display("FAIL rst_resp_pre: got vld=%b d=%h b=%h want 1 33 33", res_valid, res_data, reg_b);
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state("rst_resp");
  endtask

  task automatic test_after_reset();
    load(2'b01, 8'h7F); load(2'b10, 8'h01);
    run_alu("add_neg", 3'b000, 1'b0, 8'h80, 3'b010, 8'h80, 8'h01);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_op = 3'b000;
    cmd_dst = 1'b0; cmd_imm = 8'h00; res_ready = 1'b0;
    test_reset();
    test_load_add();
    test_nop();
    test_arith();
    test_unary();
    test_logic_chain();
    test_backpressure();
    test_reset_mid_op();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
